m3_dequant_scheduler: RTL and testbench
=======================================

# m3_dequant_scheduler

Sequences the Milestone 3 dequantization datapath for one frame of 8x8 blocks. Accepts decoded 9-bit coefficients over a valid/ready handshake and gates the dequantizer's write enable so that exactly 64 writes land per block. Manages two ping-pong coefficient RAM banks and hands each filled bank to the downstream IDCT (Milestone 2) consumer. Sits between the lossless decoder and the dequantizer / IDCT pair.

## Interface
Parameters:
- NUM_BLOCKS, 2400, blocks per frame (320x240 Y plus horizontally downsampled U and V)
- BLK_W, 12, width of the block index; must satisfy 2^BLK_W >= NUM_BLOCKS

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle pulse; honoured only in IDLE
- q_sel  in  1  quantization matrix (0 = Q0, 1 = Q1); sampled on an honoured frame_start
- coef_valid  in  1  a coefficient is offered by the decoder
- coef_ready  out  1  the scheduler accepts the coefficient this cycle
- deq_enable  out  1  dequantizer enable / RAM write enable; equals coef_valid & coef_ready
- deq_qsel  out  1  latched q_sel, driven to the dequantizer
- fill_bank  out  1  RAM bank currently being written
- blk_valid  out  1  a filled bank is available to the consumer
- blk_bank  out  1  bank offered to the consumer
- blk_done  in  1  single-cycle pulse: consumer has released blk_bank
- blk_index  out  BLK_W  index of the block being filled
- frame_done  out  1  single-cycle pulse when the frame is complete
- stall_cycles  out  16  backpressure stall count (see Configuration)

## Operation
- State is held in a 2-bit bank_full vector plus read and fill pointers. A 6-bit coef_cnt counts 0..63.
- IDLE: coef_ready = 0. On frame_start the block latches q_sel, clears coef_cnt, blk_index, bank_full and both pointers, then moves to FILL.
- FILL: coef_ready = 1. Each accept increments coef_cnt.
  - Accept with coef_cnt = 63: set bank_full[fill_bank], toggle fill_bank, wrap coef_cnt to 0, increment blk_index.
  - If that accept completed block NUM_BLOCKS-1, go to DRAIN.
  - Otherwise, if the other bank is full and blk_done is not freeing it this cycle, go to WAIT. Else stay in FILL.
- WAIT: coef_ready = 0. Go to FILL once bank_full[fill_bank] = 0.
- DRAIN: coef_ready = 0. When bank_full = 2'b00, pulse frame_done and go to IDLE.
- Consumer side:
  - blk_valid = bank_full[read_ptr]; blk_bank = read_ptr.
  - blk_done while blk_valid = 1 clears bank_full[read_ptr] and toggles read_ptr.
  - blk_done while blk_valid = 0 is ignored.
- A set and a clear of bank_full in the same cycle always target different banks, and both take effect.
- frame_start outside IDLE is ignored, and deq_qsel is not changed.
- The dequantizer's internal scan counter stays aligned because exactly 64 enables are issued per block, with no extra enables.

## Timing
- Reset values: coef_ready 0, deq_enable 0, deq_qsel 0, fill_bank 0, blk_valid 0, blk_bank 0, blk_index 0, frame_done 0, stall_cycles 0; state IDLE.
- coef_ready and blk_valid are register-driven. deq_enable is combinational, with zero latency from coef_valid.
- The 64th write and the set of bank_full share a clock edge, so blk_valid rises the cycle after the 64th accept.
- WAIT -> FILL occurs one cycle after blk_done frees fill_bank.
- No bubble occurs between blocks when the other bank is free.
- Reset asserted mid-frame discards all progress. The consumer must also be reset.

## Configuration
- SCHED_PERF_EN defined: stall_cycles counts cycles spent in WAIT. It saturates at 16'hFFFF and is cleared on an honoured frame_start.
- SCHED_PERF_EN undefined: stall_cycles is tied to 0 and no counter logic exists.

## Structure
- Shared package m3_pkg holds:
  - the state enum (IDLE, FILL, WAIT, DRAIN)
  - COEF_PER_BLK = 64
  - the default NUM_BLOCKS constant
- A single sub-module, pingpong_tracker, is natural. It owns bank_full, read_ptr and fill_ptr, exposes fill_free, rd_valid and the pointers, and takes mark_full and mark_done.

## Test plan
- Reset, then frame_start with q_sel=1 and NUM_BLOCKS=2; stream 128 back-to-back coefficients with blk_done returned 5 cycles after each blk_valid -> exactly 128 deq_enable cycles, deq_qsel=1, blk_bank sequence 0 then 1, frame_done pulses once after the second blk_done.
- Consumer never asserts blk_done, 200 coefficients offered -> 128 accepted, coef_ready low from cycle 129 onward, state WAIT. With SCHED_PERF_EN, stall_cycles increments every cycle.
- Consumer holds off, then asserts blk_done for bank 0 on the same cycle as the 128th accept -> bank 0 is freed, no WAIT entered, coef_ready stays 1.
- coef_valid toggled every other cycle -> blk_valid rises exactly one cycle after the 64th accept, and no enable is issued while coef_valid is 0.
- frame_start mid-frame with q_sel changed -> ignored: deq_qsel unchanged, counters continue.
- Reset pulsed at coefficient 30 of block 1 -> all outputs return to their reset values immediately; a new frame_start restarts at blk_index 0, fill_bank 0.

Source files
------------

// File: rtl/m3_pkg.sv
// Shared definitions for the Milestone 3 dequantization scheduler.
package m3_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWait,
        StDrain
    } sched_state_e;

    // Coefficients per 8x8 block
    localparam int unsigned COEF_PER_BLK = 64;

    // 320x240 Y plus horizontally downsampled U and V, in 8x8 blocks
    localparam int unsigned NUM_BLOCKS_DEFAULT = 2400;

endpackage

// File: rtl/pingpong_tracker.sv
// Ping-pong coefficient RAM bank tracker: which banks hold a complete block, which bank the
// dequantizer writes next and which bank the IDCT consumer reads next.
module pingpong_tracker (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic mark_full,
    input  logic mark_done,
    output logic fill_ptr,
    output logic read_ptr,
    output logic fill_free,
    output logic other_full,
    output logic rd_valid,
    output logic all_empty
);

    logic [1:0] bank_full_q, bank_full_d;
    logic       fill_ptr_q, fill_ptr_d;
    logic       read_ptr_q, read_ptr_d;
    logic       done_ok;

    // A release is only meaningful while the read bank actually holds a block
    assign done_ok = mark_done & bank_full_q[read_ptr_q];

    // Next-state: a fill completion and a release always hit different banks, so both apply
    always_comb begin
        bank_full_d = bank_full_q;
        fill_ptr_d  = fill_ptr_q;
        read_ptr_d  = read_ptr_q;
        if (clear) begin
            bank_full_d = 2'b00;
            fill_ptr_d  = 1'b0;
            read_ptr_d  = 1'b0;
        end else begin
            if (mark_full) begin
                bank_full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d              = ~fill_ptr_q;
            end
            if (done_ok) begin
                bank_full_d[read_ptr_q] = 1'b0;
                read_ptr_d              = ~read_ptr_q;
            end
        end
    end

    // Bank state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_full_q <= 2'b00;
            fill_ptr_q  <= 1'b0;
            read_ptr_q  <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            fill_ptr_q  <= fill_ptr_d;
            read_ptr_q  <= read_ptr_d;
        end
    end

    assign fill_ptr   = fill_ptr_q;
    assign read_ptr   = read_ptr_q;
    assign fill_free  = ~bank_full_q[fill_ptr_q];
    assign other_full = bank_full_q[~fill_ptr_q];
    assign rd_valid   = bank_full_q[read_ptr_q];
    assign all_empty  = (bank_full_q == 2'b00);

endmodule

// File: rtl/m3_dequant_scheduler.sv
// Milestone 3 dequantization scheduler: admits exactly 64 coefficients per 8x8 block into
// alternating RAM banks and hands each filled bank to the IDCT consumer.
// Optional feature: define SCHED_PERF_EN to count backpressure (WAIT) cycles on stall_cycles.
module m3_dequant_scheduler
    import m3_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
    parameter int unsigned BLK_W      = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             q_sel,
    input  logic             coef_valid,
    output logic             coef_ready,
    output logic             deq_enable,
    output logic             deq_qsel,
    output logic             fill_bank,
    output logic             blk_valid,
    output logic             blk_bank,
    input  logic             blk_done,
    output logic [BLK_W-1:0] blk_index,
    output logic             frame_done,
    output logic [15:0]      stall_cycles
);

    sched_state_e     state_q;
    logic [5:0]       coef_cnt_q;
    logic [BLK_W-1:0] blk_index_q;
    logic             deq_qsel_q;
    logic             coef_ready_q;
    logic             frame_done_q;

    logic start_ok, accept, last_coef, last_blk, freeing;
    logic fill_ptr, read_ptr, fill_free, other_full, rd_valid, all_empty;

    assign start_ok  = frame_start & (state_q == StIdle);
    assign accept    = coef_valid & coef_ready_q;
    assign last_coef = accept & (coef_cnt_q == 6'(COEF_PER_BLK - 1));
    assign last_blk  = (blk_index_q == BLK_W'(NUM_BLOCKS - 1));
    assign freeing   = blk_done & rd_valid;

    pingpong_tracker u_tracker (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .mark_full  (last_coef),
        .mark_done  (blk_done),
        .fill_ptr   (fill_ptr),
        .read_ptr   (read_ptr),
        .fill_free  (fill_free),
        .other_full (other_full),
        .rd_valid   (rd_valid),
        .all_empty  (all_empty)
    );

    // Control FSM with registered coef_ready / frame_done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            coef_cnt_q   <= 6'd0;
            blk_index_q  <= '0;
            deq_qsel_q   <= 1'b0;
            coef_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        deq_qsel_q   <= q_sel;
                        coef_cnt_q   <= 6'd0;
                        blk_index_q  <= '0;
                        coef_ready_q <= 1'b1;
                        state_q      <= StFill;
                    end
                end
                StFill: begin
                    if (accept) begin
                        // 6-bit counter wraps 63 -> 0 on its own at block end
                        coef_cnt_q <= coef_cnt_q + 6'd1;
                        if (last_coef) begin
                            blk_index_q <= blk_index_q + BLK_W'(1);
                            if (last_blk) begin
                                coef_ready_q <= 1'b0;
                                state_q      <= StDrain;
                            end else if (other_full && !freeing) begin
                                // Next bank still owned by the consumer
                                coef_ready_q <= 1'b0;
                                state_q      <= StWait;
                            end
                        end
                    end
                end
                StWait: begin
                    if (fill_free) begin
                        coef_ready_q <= 1'b1;
                        state_q      <= StFill;
                    end
                end
                StDrain: begin
                    if (all_empty) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles spent waiting for a free bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (start_ok) begin
            stall_q <= 16'h0000;
        end else if ((state_q == StWait) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign coef_ready = coef_ready_q;
    assign deq_enable = accept;
    assign deq_qsel   = deq_qsel_q;
    assign fill_bank  = fill_ptr;
    assign blk_valid  = rd_valid;
    assign blk_bank   = read_ptr;
    assign blk_index  = blk_index_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_m3_dequant_scheduler.sv
// Directed bench for m3_dequant_scheduler with a scoreboard of expected bank offers.
module tb_m3_dequant_scheduler;
    import m3_pkg::*;

    // Three blocks so a frame can hit WAIT before its final block
    localparam int unsigned NB = 3;
    localparam int unsigned BW = 12;

    logic          clock = 1'b0;
    logic          reset, frame_start, q_sel, coef_valid, blk_done;
    logic          coef_ready, deq_enable, deq_qsel, fill_bank, blk_valid, blk_bank, frame_done;
    logic [BW-1:0] blk_index;
    logic [15:0]   stall_cycles;

    always #5 clock = ~clock;

    m3_dequant_scheduler #(
        .NUM_BLOCKS (NB),
        .BLK_W      (BW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .q_sel        (q_sel),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .deq_enable   (deq_enable),
        .deq_qsel     (deq_qsel),
        .fill_bank    (fill_bank),
        .blk_valid    (blk_valid),
        .blk_bank     (blk_bank),
        .blk_done     (blk_done),
        .blk_index    (blk_index),
        .frame_done   (frame_done),
        .stall_cycles (stall_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Consumer controls
    logic cons_en    = 1'b0;
    int   cons_delay = 5;
    logic force_done = 1'b0;

    // Scoreboard: expected offers (bank, cycle of 64th accept) and observed offers
    typedef struct {
        int bank;
        int cyc;
        int ld;
    } ev_t;
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  exp_rd = 0;
    int  obs_rd = 0;

    // Monitor state
    int cyc = 0, blk_acc = 0, model_bank = 0, en_cnt = 0, bad_en = 0;
    int fd_cnt = 0, fd_cyc = 0, last_done = -10;
    bit prev_valid = 1'b0, prev_taken = 1'b0;

    // Monitor: samples on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset || (frame_start && dut.state_q == StIdle)) begin
                blk_acc    = 0;
                model_bank = 0;
            end else begin
                if (blk_valid && (!prev_valid || prev_taken))
                    obs_q.push_back('{bank: int'(blk_bank), cyc: cyc, ld: last_done});
                if (coef_valid && coef_ready) begin
                    blk_acc++;
                    if (blk_acc % 64 == 0) begin
                        exp_q.push_back('{bank: model_bank, cyc: cyc, ld: 0});
                        model_bank = 1 - model_bank;
                    end
                end
                if (deq_enable) en_cnt++;
                if (deq_enable && !(coef_valid && coef_ready)) bad_en++;
                if (blk_done && blk_valid) last_done = cyc;
                if (frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
            end
            prev_valid = blk_valid;
            prev_taken = blk_done && blk_valid;
        end
    end

    // Consumer: releases the offered bank cons_delay cycles after seeing it
    initial begin
        int cons_wait;
        cons_wait = 0;
        blk_done  = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            blk_done = force_done;
            if (reset || !cons_en || !blk_valid) begin
                cons_wait = 0;
            end else if (cons_wait >= cons_delay) begin
                blk_done  = 1'b1;
                cons_wait = 0;
            end else begin
                cons_wait++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic frame(input logic qs);
        frame_start = 1'b1;
        q_sel       = qs;
        @(posedge clock);
        #1;
        frame_start = 1'b0;
    endtask

    // Offer coefficients until n are accepted or max_cyc cycles pass
    task automatic stream(input int n, input bit toggle, input int done_at, input int max_cyc,
                          output int acc);
        int c;
        c   = 0;
        acc = 0;
        while (acc < n && c < max_cyc) begin
            force_done = 1'b0;
            coef_valid = toggle ? logic'((c % 2) == 0) : 1'b1;
            if (done_at > 0 && acc == done_at - 1 && coef_valid && coef_ready)
                force_done = 1'b1;
            @(negedge clock);
            if (coef_valid && coef_ready) acc++;
            @(posedge clock);
            #1;
            c++;
        end
        coef_valid = 1'b0;
        force_done = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int bound);
        int found;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (frame_done) begin
                found = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        check({tag, "_frame_done_seen"}, found, 1);
        check({tag, "_frame_done_timing"}, fd_cyc, last_done + 2);
    endtask

    // Pair observed offers with expected ones: bank order and offer cycle
    task automatic check_offers(input string tag, input int n);
        int exp_cyc;
        check({tag, "_offer_count"}, obs_q.size() - obs_rd, n);
        for (int i = 0; i < n; i++) begin
            if (obs_rd + i < obs_q.size() && exp_rd + i < exp_q.size()) begin
                exp_cyc = exp_q[exp_rd + i].cyc + 1;
                if (obs_q[obs_rd + i].ld + 1 > exp_cyc) exp_cyc = obs_q[obs_rd + i].ld + 1;
                check({tag, "_offer_bank"}, obs_q[obs_rd + i].bank, exp_q[exp_rd + i].bank);
                check({tag, "_offer_cycle"}, obs_q[obs_rd + i].cyc, exp_cyc);
            end
        end
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coef_ready"}, coef_ready, 0);
        check({tag, "_deq_enable"}, deq_enable, 0);
        check({tag, "_deq_qsel"}, deq_qsel, 0);
        check({tag, "_fill_bank"}, fill_bank, 0);
        check({tag, "_blk_valid"}, blk_valid, 0);
        check({tag, "_blk_bank"}, blk_bank, 0);
        check({tag, "_blk_index"}, blk_index, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_stall"}, stall_cycles, 0);
        check({tag, "_state"}, dut.state_q, StIdle);
    endtask

    initial begin
        int acc, en0, fd0, bad0, s0;
        reset       = 1'b0;
        frame_start = 1'b0;
        q_sel       = 1'b0;
        coef_valid  = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        ticks(2);

        // Back-to-back frame, consumer answers 5 cycles after each offer
        cons_en    = 1'b1;
        cons_delay = 5;
        en0        = en_cnt;
        fd0        = fd_cnt;
        frame(1'b1);
        stream(192, 1'b0, 0, 400, acc);
        check("t1_accepts", acc, 192);
        wait_fd("t1", 100);
        ticks(3);
        check("t1_enables", en_cnt - en0, 192);
        check("t1_deq_qsel", deq_qsel, 1);
        check("t1_frame_done_once", fd_cnt - fd0, 1);
        check("t1_state_idle", dut.state_q, StIdle);
        check_offers("t1", 3);

        // Consumer never releases: two banks fill, then WAIT
        cons_en = 1'b0;
        en0     = en_cnt;
        frame(1'b0);
        stream(200, 1'b0, 0, 200, acc);
        check("t2_accepts", acc, 128);
        check("t2_coef_ready", coef_ready, 0);
        check("t2_state_wait", dut.state_q, StWait);
        check("t2_blk_valid", blk_valid, 1);
        check("t2_blk_bank", blk_bank, 0);
        check("t2_deq_qsel", deq_qsel, 0);
        check("t2_enables", en_cnt - en0, 128);
`ifdef SCHED_PERF_EN
        s0 = int'(stall_cycles);
        check("t2_stall_nonzero", s0 > 0, 1);
        ticks(10);
        check("t2_stall_delta", int'(stall_cycles) - s0, 10);
`else
        s0 = 0;
        ticks(10);
        check("t2_stall_zero", int'(stall_cycles) + s0, 0);
`endif
        check_offers("t2", 1);
        reset = 1'b1;
        ticks(1);
        reset = 1'b0;
        ticks(1);
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();

        // Release of bank 0 coincides with the 128th accept: no WAIT
        frame(1'b1);
        stream(128, 1'b0, 128, 200, acc);
        check("t3_accepts", acc, 128);
        check("t3_state_fill", dut.state_q, StFill);
        check("t3_coef_ready", coef_ready, 1);
        check("t3_blk_valid", blk_valid, 1);
        check("t3_blk_bank", blk_bank, 1);
        check("t3_fill_bank", fill_bank, 0);
        check("t3_stall", stall_cycles, 0);
        cons_en    = 1'b1;
        cons_delay = 2;
        stream(64, 1'b0, 0, 100, acc);
        check("t3_tail_accepts", acc, 64);
        wait_fd("t3", 100);
        check_offers("t3", 3);

        // coef_valid every other cycle
        cons_delay = 3;
        en0        = en_cnt;
        bad0       = bad_en;
        frame(1'b1);
        stream(192, 1'b1, 0, 600, acc);
        check("t4_accepts", acc, 192);
        wait_fd("t4", 100);
        check("t4_enables", en_cnt - en0, 192);
        check("t4_stray_enables", bad_en - bad0, 0);
        check_offers("t4", 3);

        // frame_start mid-frame with a different q_sel is ignored
        cons_delay = 2;
        frame(1'b0);
        stream(100, 1'b0, 0, 200, acc);
        check("t5_accepts_a", acc, 100);
        frame(1'b1);
        check("t5_deq_qsel", deq_qsel, 0);
        check("t5_blk_index", blk_index, 1);
        check("t5_coef_cnt", dut.coef_cnt_q, 36);
        check("t5_state_fill", dut.state_q, StFill);
        stream(92, 1'b0, 0, 200, acc);
        check("t5_accepts_b", acc, 92);
        wait_fd("t5", 100);
        check_offers("t5", 3);

        // Reset at coefficient 30 of block 1
        frame(1'b1);
        stream(94, 1'b0, 0, 200, acc);
        check("t6_accepts", acc, 94);
        check("t6_pre_blk_index", blk_index, 1);
        check("t6_pre_fill_bank", fill_bank, 1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();
        frame(1'b0);
        check("t6_restart_blk_index", blk_index, 0);
        check("t6_restart_fill_bank", fill_bank, 0);
        check("t6_restart_coef_ready", coef_ready, 1);
        stream(192, 1'b0, 0, 400, acc);
        check("t6_restart_accepts", acc, 192);
        wait_fd("t6", 100);
        check_offers("t6", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
